register_load_sequencer: RTL and testbench
==========================================

REGISTER_LOAD_SEQUENCER -- requirements
Module: register_load_sequencer

Interface
REQ-001 Parameter: ADDR_WIDTH, 16, width of MemAddr and BaseAddr.
REQ-002 Port: Clock  input  1  sole clock; all state updates on posedge.
REQ-003 Port: Reset  input  1  synchronous, active-high reset.
REQ-004 Port: Start  input  1  load request, sampled only in IDLE.
REQ-005 Port: ByteCount  input  3  bytes to load; legal 1..4.
REQ-006 Port: BaseAddr  input  ADDR_WIDTH  address of first (most-significant) byte.
REQ-007 Port: SignExt  input  1  request 16-bit sign extension after a 2-byte load.
REQ-008 Port: MemAddr  output  ADDR_WIDTH  byte-memory read address.
REQ-009 Port: MemRd  output  1  byte-memory read strobe.
REQ-010 Port: MemData  input  8  read data, valid the cycle after MemRd.
REQ-011 Port: RegE  output  1  target 32-bit register enable.
REQ-012 Port: RegFunSel  output  3  target register function select.
REQ-013 Port: RegI  output  32  target register data input.
REQ-014 Port: Busy  output  1  high in every state except IDLE.
REQ-015 Port: Done  output  1  one-cycle completion pulse.
REQ-016 Port: Error  output  1  one-cycle pulse on illegal ByteCount.

Function
REQ-017 States SHALL be IDLE, READ, LOAD, SEXT, DONE.
REQ-018 In IDLE with Start=1 and ByteCount in 1..4: latch BaseAddr, ByteCount, SignExt; clear byte index k; go to READ.
REQ-019 In IDLE with Start=1 and ByteCount of 0 or 5..7: pulse Error next cycle; stay IDLE; no MemRd, no RegE.
REQ-020 READ: MemRd=1, MemAddr=latched BaseAddr+k (mod 2^ADDR_WIDTH, wrap allowed); next state LOAD.
REQ-021 LOAD: RegE=1, RegI={24'b0,MemData}; RegFunSel=3'b100 for k=0, 3'b110 for k>0; shadow register takes {shadow[23:0],MemData}.
REQ-022 From LOAD: if k+1 < ByteCount then k increments and next state is READ; otherwise go to SEXT when REQ-030 applies, else DONE.
REQ-023 DONE: Done=1 for exactly one cycle; next state IDLE.
REQ-024 Result is big-endian: byte at BaseAddr ends in bits [8N-1:8N-8] of the target; upper bits zero.
REQ-025 Latency: Start accepted in cycle 0 -> first MemRd in cycle 1 -> Done in cycle 2N+1 (2N+2 with SEXT).
REQ-026 Start, ByteCount, BaseAddr, SignExt SHALL be ignored while Busy=1.
REQ-027 When RegE=0, RegFunSel=3'b000 and RegI=0; MemRd=0 and MemAddr=0 outside READ.
REQ-028 Start may be accepted in the cycle immediately after Done (back-to-back).

Reset
REQ-029 Reset=1 at a posedge SHALL force IDLE, clear k and shadow, and drive Busy, Done, Error, MemRd, RegE to 0 (MemAddr, RegFunSel, RegI to 0) from the next cycle, aborting any load in progress with no further RegE pulse; Reset has priority over Start.

Configuration
REQ-030 With SIGN_EXT_EN defined: if latched SignExt=1 and ByteCount=2, one SEXT cycle follows the last LOAD, with RegE=1, RegFunSel=3'b111, RegI={16'b0,shadow[15:0]}, then DONE.
REQ-031 Without SIGN_EXT_EN: SEXT is unreachable, SignExt is ignored, and the port remains present.

Verification
REQ-032 Start, ByteCount=4, BaseAddr=0x0010, mem[0x10..0x13]=0x12,0x34,0x56,0x78 -> FunSel 100,110,110,110; target=0x12345678; Done in cycle 9.
REQ-033 ByteCount=0 and separately ByteCount=5 -> one-cycle Error pulse, Busy stays 0, no MemRd/RegE.
REQ-034 BaseAddr=0xFFFF, ByteCount=2, mem[0xFFFF]=0xAB, mem[0x0000]=0xCD -> MemAddr 0xFFFF then 0x0000; target=0x0000ABCD.
REQ-035 SIGN_EXT_EN defined, SignExt=1, ByteCount=2, bytes 0x80,0x01 -> SEXT cycle with FunSel 111, RegI=0x00008001; target=0xFFFF8001; Done in cycle 6; same stimulus without macro -> target=0x00008001, Done in cycle 5.
REQ-036 Reset asserted during second LOAD of a 4-byte load -> next cycle Busy=0, RegE=0, no Done; a new Start then completes normally.
REQ-037 Start held high across a load -> ignored while Busy; a second load starts the cycle after Done.

Source files
------------

// File: rtl/register_load_sequencer.sv
// ============================================================================
// register_load_sequencer
//
// Purpose:
//   Loads 1..4 bytes from a byte-wide memory into a 32-bit target register.
//   Bytes are read starting at BaseAddr, one per READ/LOAD pair. The first
//   byte is written with a plain load and later bytes shift the register
//   left by 8, so the result ends up big-endian and zero-extended.
//   Optionally, a 2-byte load can be followed by a 16-bit sign extension.
//
// Configuration macro:
//   SIGN_EXT_EN - when defined, a latched SignExt=1 on a 2-byte load adds one
//                 SEXT cycle (RegFunSel=3'b111) before DONE. When undefined,
//                 SEXT is unreachable and SignExt is ignored.
//
// Ports:
//   Clock      in   sole clock, rising edge
//   Reset      in   synchronous, active-high
//   Start      in   load request, only looked at in IDLE
//   ByteCount  in   [2:0] bytes to load, legal 1..4
//   BaseAddr   in   [ADDR_WIDTH-1:0] address of the most-significant byte
//   SignExt    in   request 16-bit sign extension after a 2-byte load
//   MemAddr    out  [ADDR_WIDTH-1:0] byte-memory read address (READ only)
//   MemRd      out  byte-memory read strobe
//   MemData    in   [7:0] read data, valid the cycle after MemRd
//   RegE       out  target register enable
//   RegFunSel  out  [2:0] target function: 100 load, 110 shift-in, 111 sext
//   RegI       out  [31:0] target register data
//   Busy       out  high in every state except IDLE
//   Done       out  one-cycle completion pulse
//   Error      out  one-cycle pulse after a request with illegal ByteCount
// ============================================================================
module register_load_sequencer #(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [2:0]            ByteCount,
   input  logic [ADDR_WIDTH-1:0] BaseAddr,
   input  logic                  SignExt,
   output logic [ADDR_WIDTH-1:0] MemAddr,
   output logic                  MemRd,
   input  logic [7:0]            MemData,
   output logic                  RegE,
   output logic [2:0]            RegFunSel,
   output logic [31:0]           RegI,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Error
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      LOAD = 3'd2,
      SEXT = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam logic [2:0] FS_NONE  = 3'b000;
   localparam logic [2:0] FS_LOAD  = 3'b100;
   localparam logic [2:0] FS_SHIFT = 3'b110;
   localparam logic [2:0] FS_SEXT  = 3'b111;

   state_t                r_state;
   state_t                w_next_state;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [2:0]            r_count;
   logic [1:0]            r_k;
   // Only the last two loaded bytes are ever consumed (by SEXT), so the
   // shadow copy keeps just the low 16 bits of the assembled word.
   logic [15:0]           r_shadow;
   logic                  r_error;

   logic                  w_count_ok;
   logic                  w_accept;
   logic                  w_reject;
   logic                  w_more;
   logic                  w_sext_go;

`ifdef SIGN_EXT_EN
   logic                  r_signext;
`else
   logic                  w_unused_signext;
`endif

   assign w_count_ok = (ByteCount != 3'd0) && (ByteCount <= 3'd4);
   assign w_accept   = (r_state == IDLE) && Start && w_count_ok;
   assign w_reject   = (r_state == IDLE) && Start && !w_count_ok;

   // k is at most 3 and ByteCount at most 4, so the 3-bit sum cannot wrap.
   assign w_more     = ({1'b0, r_k} + 3'd1) < r_count;

`ifdef SIGN_EXT_EN
   assign w_sext_go  = r_signext && (r_count == 3'd2);
`else
   assign w_sext_go        = 1'b0;
   assign w_unused_signext = SignExt;
`endif

   assign Busy  = (r_state != IDLE);
   assign Error = r_error;

   // Control state: reset aborts any load in progress.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state  <= IDLE;
         r_k      <= '0;
         r_shadow <= '0;
         r_error  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_error <= w_reject;
         if (w_accept) begin
            r_k      <= '0;
            r_shadow <= '0;
         end else if (r_state == LOAD) begin
            r_shadow <= {r_shadow[7:0], MemData};
            if (w_more) begin
               r_k <= r_k + 2'd1;
            end
         end
      end
   end

   // Request operands are captured once on acceptance and held for the
   // whole load, so input changes while Busy have no effect.
   always_ff @(posedge Clock) begin
      if (w_accept && !Reset) begin
         r_base    <= BaseAddr;
         r_count   <= ByteCount;
`ifdef SIGN_EXT_EN
         r_signext <= SignExt;
`endif
      end
   end

   always_comb begin
      w_next_state = r_state;
      MemRd        = 1'b0;
      MemAddr      = '0;
      RegE         = 1'b0;
      RegFunSel    = FS_NONE;
      RegI         = '0;
      Done         = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next_state = READ;
            end
         end

         READ: begin
            MemRd        = 1'b1;
            // Address arithmetic wraps modulo 2^ADDR_WIDTH.
            MemAddr      = r_base + ADDR_WIDTH'(r_k);
            w_next_state = LOAD;
         end

         LOAD: begin
            RegE      = 1'b1;
            RegI      = {24'b0, MemData};
            RegFunSel = (r_k == 2'd0) ? FS_LOAD : FS_SHIFT;
            if (w_more) begin
               w_next_state = READ;
            end else if (w_sext_go) begin
               w_next_state = SEXT;
            end else begin
               w_next_state = DONE;
            end
         end

         SEXT: begin
            RegE         = 1'b1;
            RegFunSel    = FS_SEXT;
            RegI         = {16'b0, r_shadow};
            w_next_state = DONE;
         end

         DONE: begin
            Done         = 1'b1;
            w_next_state = IDLE;
         end

         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_register_load_sequencer.sv
`timescale 1ns/1ps
module tb_register_load_sequencer;

   localparam int AW = 16;

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic          Start = 1'b0;
   logic [2:0]    ByteCount = 3'd0;
   logic [AW-1:0] BaseAddr = '0;
   logic          SignExt = 1'b0;
   logic [AW-1:0] MemAddr;
   logic          MemRd;
   logic [7:0]    MemData = 8'h00;
   logic          RegE;
   logic [2:0]    RegFunSel;
   logic [31:0]   RegI;
   logic          Busy;
   logic          Done;
   logic          Error;

   register_load_sequencer #(.ADDR_WIDTH(AW)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Start     (Start),
      .ByteCount (ByteCount),
      .BaseAddr  (BaseAddr),
      .SignExt   (SignExt),
      .MemAddr   (MemAddr),
      .MemRd     (MemRd),
      .MemData   (MemData),
      .RegE      (RegE),
      .RegFunSel (RegFunSel),
      .RegI      (RegI),
      .Busy      (Busy),
      .Done      (Done),
      .Error     (Error)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [7:0]  mem [0:65535];
   logic [31:0] tgt = 32'h0;

   typedef struct {
      logic [31:0] target;
      int          done_cyc;
      logic [14:0] fs;
      int          nfs;
      logic [63:0] addrs;
      int          nrd;
      logic [31:0] sext_regi;
   } exp_t;

   exp_t sb[$];

   logic        mon_en = 1'b0;
   logic [14:0] obs_fs;
   int          obs_nfs;
   logic [63:0] obs_addr;
   int          obs_nrd;
   logic [31:0] obs_sext;
   int          rd_total = 0;
   int          rege_total = 0;

   initial forever #5 Clock = ~Clock;

   always @(posedge Clock) cyc <= cyc + 1;

   // Byte memory: data appears the cycle after the read strobe.
   always @(posedge Clock) begin
      if (MemRd) MemData <= mem[MemAddr];
   end

   // Target 32-bit register driven by RegE/RegFunSel/RegI.
   always @(posedge Clock) begin
      if (RegE) begin
         case (RegFunSel)
            3'b100:  tgt <= RegI;
            3'b110:  tgt <= {tgt[23:0], RegI[7:0]};
            3'b111:  tgt <= {{16{RegI[15]}}, RegI[15:0]};
            default: tgt <= tgt;
         endcase
      end
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic clear_obs();
      obs_fs   = '0;
      obs_nfs  = 0;
      obs_addr = '0;
      obs_nrd  = 0;
      obs_sext = '0;
   endtask

   // Monitor: collects per-load activity, enforces idle-output rules, and
   // pops the scoreboard on every Done.
   initial begin
      exp_t e;
      clear_obs();
      forever begin
         @(negedge Clock);
         if (mon_en) begin
            if (!RegE) begin
               check("idle_funsel", 64'(RegFunSel), 64'(0));
               check("idle_regi", 64'(RegI), 64'(0));
            end
            if (!MemRd) check("idle_memaddr", 64'(MemAddr), 64'(0));
            if (MemRd) begin
               rd_total++;
               if (obs_nrd < 4) obs_addr[16*obs_nrd +: 16] = MemAddr;
               obs_nrd++;
            end
            if (RegE) begin
               rege_total++;
               if (obs_nfs < 5) obs_fs[3*obs_nfs +: 3] = RegFunSel;
               obs_nfs++;
               if (RegFunSel == 3'b111) obs_sext = RegI;
            end
            if (Done) begin
               if (sb.size() == 0) begin
                  check("unexpected_done", 64'(1), 64'(0));
               end else begin
                  e = sb.pop_front();
                  check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                  check("target", 64'(tgt), 64'(e.target));
                  check("funsel_seq", 64'(obs_fs), 64'(e.fs));
                  check("rege_count", 64'(obs_nfs), 64'(e.nfs));
                  check("memaddr_seq", obs_addr, e.addrs);
                  check("memrd_count", 64'(obs_nrd), 64'(e.nrd));
                  check("sext_regi", 64'(obs_sext), 64'(e.sext_regi));
               end
               clear_obs();
            end else if (!Busy) begin
               clear_obs();
            end
         end
      end
   end

   task automatic push_load(input logic [15:0] base, input int n, input logic sx, input int c0);
      exp_t        e;
      logic [31:0] t;
      logic [15:0] a;
      logic        do_sx;
      t = '0;
      e.fs = '0;
      e.addrs = '0;
      for (int i = 0; i < n; i++) begin
         a = base + 16'(i);
         t = {t[23:0], mem[a]};
         e.addrs[16*i +: 16] = a;
         e.fs[3*i +: 3] = (i == 0) ? 3'b100 : 3'b110;
      end
`ifdef SIGN_EXT_EN
      do_sx = sx && (n == 2);
`else
      do_sx = sx & 1'b0;
`endif
      e.sext_regi = '0;
      if (do_sx) begin
         e.sext_regi = {16'b0, t[15:0]};
         t = {{16{t[15]}}, t[15:0]};
         e.fs[3*n +: 3] = 3'b111;
      end
      e.target   = t;
      e.nfs      = n + (do_sx ? 1 : 0);
      e.nrd      = n;
      e.done_cyc = c0 + 2*n + 1 + (do_sx ? 1 : 0);
      sb.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge Clock);
      #1;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (Busy === 1'b1 && k < 100) begin
         next_cycle();
         k++;
      end
      if (Busy !== 1'b0) check("idle_timeout", 64'(Busy), 64'(0));
   endtask

   // One legal load; inputs are scrambled while Busy to show they are ignored.
   task automatic run_load(input logic [15:0] base, input logic [2:0] n, input logic sx);
      wait_idle();
      BaseAddr  = base;
      ByteCount = n;
      SignExt   = sx;
      Start     = 1'b1;
      push_load(base, int'(n), sx, cyc);
      next_cycle();
      for (int j = 1; j <= 2*int'(n); j++) begin
         Start     = 1'($urandom);
         BaseAddr  = 16'($urandom);
         ByteCount = 3'($urandom);
         SignExt   = 1'($urandom);
         next_cycle();
      end
      Start = 1'b0;
      wait_idle();
   endtask

   task automatic bad_start(input logic [2:0] n);
      int r0;
      int e0;
      wait_idle();
      r0 = rd_total;
      e0 = rege_total;
      BaseAddr  = 16'h0100;
      ByteCount = n;
      Start     = 1'b1;
      next_cycle();
      Start = 1'b0;
      check("err_pulse", 64'(Error), 64'(1));
      check("err_busy", 64'(Busy), 64'(0));
      next_cycle();
      check("err_one_cycle", 64'(Error), 64'(0));
      check("err_busy_after", 64'(Busy), 64'(0));
      next_cycle();
      check("err_no_memrd", 64'(rd_total - r0), 64'(0));
      check("err_no_rege", 64'(rege_total - e0), 64'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
      mem[16'h0010] = 8'h12; mem[16'h0011] = 8'h34;
      mem[16'h0012] = 8'h56; mem[16'h0013] = 8'h78;
      mem[16'hFFFF] = 8'hAB; mem[16'h0000] = 8'hCD;
      mem[16'h0040] = 8'h80; mem[16'h0041] = 8'h01;
      mem[16'h0050] = 8'h7F; mem[16'h0051] = 8'hFE;

      Reset = 1'b1;
      repeat (3) @(posedge Clock);
      #1;
      check("rst_busy", 64'(Busy), 64'(0));
      check("rst_done", 64'(Done), 64'(0));
      check("rst_error", 64'(Error), 64'(0));
      check("rst_memrd", 64'(MemRd), 64'(0));
      check("rst_rege", 64'(RegE), 64'(0));
      check("rst_memaddr", 64'(MemAddr), 64'(0));
      check("rst_funsel", 64'(RegFunSel), 64'(0));
      check("rst_regi", 64'(RegI), 64'(0));
      Reset  = 1'b0;
      mon_en = 1'b1;
      next_cycle();

      // Four-byte big-endian load.
      run_load(16'h0010, 3'd4, 1'b0);

      // Illegal byte counts.
      bad_start(3'd0);
      bad_start(3'd5);
      bad_start(3'd7);

      // Address wrap at the top of memory.
      run_load(16'hFFFF, 3'd2, 1'b0);

      // Sign extension requests: 2-byte (extends when enabled), 3-byte (never).
      run_load(16'h0040, 3'd2, 1'b1);
      run_load(16'h0050, 3'd2, 1'b1);
      run_load(16'h0040, 3'd3, 1'b1);
      run_load(16'h0013, 3'd1, 1'b0);

      // Reset during the second LOAD of a four-byte load.
      wait_idle();
      c = cyc;
      BaseAddr  = 16'h0200;
      ByteCount = 3'd4;
      SignExt   = 1'b0;
      Start     = 1'b1;
      next_cycle();
      Start = 1'b0;
      repeat (3) next_cycle();
      check("abort_at_load", 64'(RegE), 64'(1));
      check("abort_cycle", 64'(cyc), 64'(c + 4));
      Reset = 1'b1;
      next_cycle();
      check("abort_busy", 64'(Busy), 64'(0));
      check("abort_rege", 64'(RegE), 64'(0));
      check("abort_done", 64'(Done), 64'(0));
      check("abort_memrd", 64'(MemRd), 64'(0));
      Reset = 1'b0;
      repeat (3) next_cycle();
      check("abort_stays_idle", 64'(Busy), 64'(0));
      run_load(16'h0010, 3'd4, 1'b0);

      // Start held high: second load begins the cycle after Done.
      wait_idle();
      c = cyc;
      BaseAddr  = 16'h0300;
      ByteCount = 3'd3;
      SignExt   = 1'b0;
      Start     = 1'b1;
      push_load(16'h0300, 3, 1'b0, c);
      push_load(16'h0300, 3, 1'b0, c + 8);
      repeat (8) next_cycle();
      check("b2b_idle_gap", 64'(Busy), 64'(0));
      next_cycle();
      Start = 1'b0;
      check("b2b_restarted", 64'(Busy), 64'(1));
      wait_idle();

      // Random legal loads.
      for (int i = 0; i < 6; i++) begin
         run_load(16'($urandom), 3'($urandom_range(1, 4)), 1'($urandom));
      end

      wait_idle();
      repeat (3) next_cycle();
      check("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
